// File: rtl/hyperbus_resp_mem.sv
// HyperBus device-side responder on a word-folded, single-clock view of the link.
// Optional feature macro HYPERBUS_RESP_VARLAT_EN: refresh-driven doubled latency flagged on RWDS during CA.
module hyperbus_resp_mem #(
  parameter int unsigned DepthWords    = 1024,
  parameter int unsigned LatencyCycles = 6,
  parameter int unsigned WrapWords     = 16,
  parameter logic [15:0] Cr0Reset      = 16'h8f1f
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o,
  input  logic        refresh_i,
  output logic [15:0] cr0_o,
  output logic        busy_o,
  output logic [2:0]  dbg_state_o
);
  localparam int unsigned AW   = $clog2(DepthWords);
  localparam int unsigned CntW = $clog2(2 * LatencyCycles + 1);
  localparam logic [AW-1:0] WrapMask = AW'(WrapWords - 1);

  typedef enum logic [2:0] {IDLE, CA1, CA2, LAT, RD, WR, REGWR, WAITCS} state_e;

  // Handshake: no valid/ready; a transaction lives while cs_ni is low, and
  // cs_ni high in any state aborts it, dropping output enables in that cycle.
  state_e          state_q, state_d;
  logic [15:0]     ca0_q, ca1_q;
  logic [AW-1:0]   addr_q, addr_nxt, rd_addr;
  logic [CntW-1:0] cnt_q, lat_init;
  logic [15:0]     dq_q, cr0_q, rd_word;
  logic [15:0]     mem [DepthWords];
  logic [31:0]     ca_addr;
  logic            is_read, is_reg, is_linear;
  logic            ca_phase;
  logic [1:0]      ca_rwds;

  assign is_read   = ca0_q[15];
  assign is_reg    = ca0_q[14];
  assign is_linear = ca0_q[13];
  // Only meaningful in CA2, when dq_i carries CA[15:0].
  assign ca_addr   = {ca0_q[12:0], ca1_q, dq_i[2:0]};

  assign addr_nxt = is_linear ? addr_q + AW'(1)
                              : (addr_q & ~WrapMask) | ((addr_q + AW'(1)) & WrapMask);

  // The output register is loaded one cycle ahead, so RD fetches the next address.
  assign rd_addr = (state_q == RD) ? addr_nxt : addr_q;
  assign rd_word = is_reg ? ((rd_addr == '0) ? cr0_q : 16'h0000) : mem[rd_addr];

`ifdef HYPERBUS_RESP_VARLAT_EN
  logic refresh_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      refresh_q <= 1'b0;
    end else if (state_q == IDLE && !cs_ni) begin
      refresh_q <= refresh_i;
    end
  end

  assign lat_init = refresh_q ? CntW'(2 * LatencyCycles) : CntW'(LatencyCycles);
  assign ca_phase = (state_q == IDLE || state_q == CA1 || state_q == CA2) && !cs_ni;
  assign ca_rwds  = (state_q == IDLE) ? {2{refresh_i}} : {2{refresh_q}};
`else
  logic unused_refresh;

  assign unused_refresh = refresh_i;
  assign lat_init       = CntW'(LatencyCycles);
  assign ca_phase       = 1'b0;
  assign ca_rwds        = 2'b00;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_ni) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CA1;
        CA1:     state_d = CA2;
        CA2:     state_d = (!is_read && is_reg) ? REGWR : LAT;
        LAT:     if (cnt_q == CntW'(1)) state_d = is_read ? RD : WR;
        REGWR:   state_d = WAITCS;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ca0_q  <= '0;
      ca1_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      dq_q   <= '0;
      cr0_q  <= Cr0Reset;
    end else begin
      dq_q <= '0;
      if (!cs_ni) begin
        case (state_q)
          IDLE: ca0_q <= dq_i;
          CA1:  ca1_q <= dq_i;
          CA2: begin
            addr_q <= AW'(ca_addr);
            cnt_q  <= lat_init;
          end
          LAT: begin
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1) && is_read) dq_q <= rd_word;
          end
          RD: begin
            addr_q <= addr_nxt;
            dq_q   <= rd_word;
          end
          WR:    addr_q <= addr_nxt;
          REGWR: if (addr_q == '0) cr0_q <= dq_i;
          default: ;
        endcase
      end
    end
  end

  // Memory has no reset; a byte lane is written only when its RWDS mask bit is 0.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !cs_ni && state_q == WR) begin
      if (!rwds_i[1]) mem[addr_q][15:8] <= dq_i[15:8];
      if (!rwds_i[0]) mem[addr_q][7:0]  <= dq_i[7:0];
    end
  end

  always_comb begin
    dq_oe_o   = (state_q == RD) && !cs_ni;
    rwds_oe_o = dq_oe_o || ca_phase;
    rwds_o    = 2'b00;
    if (dq_oe_o) begin
      rwds_o = 2'b10;
    end else if (ca_phase) begin
      rwds_o = ca_rwds;
    end
  end

  assign dq_o        = dq_q;
  assign cr0_o       = cr0_q;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hyperbus_resp_mem.sv
// Self-checking bench for hyperbus_resp_mem: address-table bursts, hand-built corner sequences
// and randomized transactions against a word-array memory model.
module tb_hyperbus_resp_mem;
  localparam int Depth = 1024;
  localparam int Lat   = 6;
  localparam int Wrap  = 16;
  localparam logic [15:0] Cr0Rst = 16'h8f1f;
`ifdef HYPERBUS_RESP_VARLAT_EN
  localparam bit VarLat = 1'b1;
`else
  localparam bit VarLat = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n, cs_n, refresh;
  logic [15:0] dq_in;
  logic [1:0]  rwds_in;
  logic [15:0] dq_out, cr0;
  logic        dq_oe, rwds_oe, busy;
  logic [1:0]  rwds_out;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  hyperbus_resp_mem dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cs_ni      (cs_n),
    .dq_i       (dq_in),
    .rwds_i     (rwds_in),
    .dq_o       (dq_out),
    .dq_oe_o    (dq_oe),
    .rwds_o     (rwds_out),
    .rwds_oe_o  (rwds_oe),
    .refresh_i  (refresh),
    .cr0_o      (cr0),
    .busy_o     (busy),
    .dbg_state_o(dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] model_mem [Depth];
  logic [15:0] model_cr0;
  logic [15:0] exp_q[$];
  logic [15:0] wdata [Depth];
  logic [1:0]  wmask [Depth];
  logic [15:0] s_dq, s_cr0;
  logic        s_dq_oe, s_rwds_oe, s_busy;
  logic [1:0]  s_rwds;

  typedef struct packed {
    logic        lin;
    logic [31:0] start;
    logic [3:0][9:0] exp_addr;
  } rd_vec_t;

  rd_vec_t vecs [7];

  function automatic rd_vec_t mk_vec(input logic lin, input logic [31:0] start,
                                     input int a0, input int a1, input int a2, input int a3);
    rd_vec_t v;
    v.lin = lin;
    v.start = start;
    v.exp_addr[0] = 10'(a0);
    v.exp_addr[1] = 10'(a1);
    v.exp_addr[2] = 10'(a2);
    v.exp_addr[3] = 10'(a3);
    return v;
  endfunction

  function automatic int unsigned addr_at(input logic lin, input logic [31:0] a, input int i);
    int unsigned s, off;
    s = a % 32'(Depth);
    if (lin) return (s + int'(i)) % Depth;
    off = s % Wrap;
    return s - off + (off + int'(i)) % Wrap;
  endfunction

  function automatic logic [15:0] exp_word(input logic rs, input logic lin, input logic [31:0] a,
                                           input int i);
    int unsigned ad;
    ad = addr_at(lin, a, i);
    if (rs) return (ad == 0) ? model_cr0 : 16'h0000;
    return model_mem[ad];
  endfunction

  function automatic int lat_for(input logic r);
    return (VarLat && r) ? 2 * Lat : Lat;
  endfunction

  function automatic logic [47:0] make_ca(input logic rd, input logic rs, input logic lin,
                                          input logic [31:0] a);
    logic [47:0] ca;
    ca[47]    = rd;
    ca[46]    = rs;
    ca[45]    = lin;
    ca[44:16] = a[31:3];
    ca[15:3]  = 13'($urandom);
    ca[2:0]   = a[2:0];
    return ca;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_wr(input int unsigned ad, input logic [15:0] d, input logic [1:0] m);
    if (!m[1]) model_mem[ad][15:8] = d[15:8];
    if (!m[0]) model_mem[ad][7:0]  = d[7:0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic cs, input logic [15:0] dq, input logic [1:0] rw, input logic rf);
    cs_n    = cs;
    dq_in   = dq;
    rwds_in = rw;
    refresh = rf;
    @(negedge clk);
    s_dq      = dq_out;
    s_dq_oe   = dq_oe;
    s_rwds    = rwds_out;
    s_rwds_oe = rwds_oe;
    s_busy    = busy;
    s_cr0     = cr0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b1, 16'($urandom), 2'($urandom), 1'($urandom));
  endtask

  task automatic send_ca(input logic rd, input logic rs, input logic lin, input logic [31:0] a,
                         input logic refr);
    logic [47:0] ca;
    logic [2:0]  exp_ca;
    ca = make_ca(rd, rs, lin, a);
    exp_ca = VarLat ? {1'b1, {2{refr}}} : 3'b000;
    cycle(1'b0, ca[47:32], 2'($urandom), refr);
    check("ca1_rwds", 32'({s_rwds_oe, s_rwds}), 32'(exp_ca));
    cycle(1'b0, ca[31:16], 2'($urandom), ~refr);
    check("ca2_rwds", 32'({s_rwds_oe, s_rwds}), 32'(exp_ca));
    cycle(1'b0, ca[15:0], 2'($urandom), 1'($urandom));
    check("ca3_rwds", 32'({s_rwds_oe, s_rwds}), 32'(exp_ca));
  endtask

  task automatic latency(input logic refr);
    int l;
    l = lat_for(refr);
    for (int i = 0; i < l; i++) begin
      cycle(1'b0, 16'($urandom), 2'($urandom), 1'($urandom));
      if (i == l - 1) check("lat_oe", 32'({s_dq_oe, s_busy}), 32'b01);
    end
  endtask

  task automatic do_read(input logic rs, input logic lin, input logic [31:0] a, input int n,
                         input logic refr, input bit use_q);
    send_ca(1'b1, rs, lin, a, refr);
    latency(refr);
    for (int i = 0; i < n; i++) begin
      if (!use_q) exp_q.push_back(exp_word(rs, lin, a, i));
      cycle(1'b0, 16'($urandom), 2'($urandom), 1'($urandom));
      check("rd_data", 32'(s_dq), 32'(exp_q.pop_front()));
      check("rd_ctl", 32'({s_dq_oe, s_rwds_oe, s_rwds}), 32'b1110);
    end
    idle_cycle();
    check("rd_end_oe", 32'({s_dq_oe, s_rwds_oe}), 32'b00);
  endtask

  task automatic do_write(input logic lin, input logic [31:0] a, input int n, input logic refr,
                          input int abort_at);
    send_ca(1'b0, 1'b0, lin, a, refr);
    latency(refr);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        cycle(1'b1, wdata[i], wmask[i], 1'b0);
        check("abort_oe", 32'({s_dq_oe, s_rwds_oe}), 32'b00);
        check("abort_busy_now", 32'(s_busy), 32'd1);
        idle_cycle();
        check("abort_busy_after", 32'(s_busy), 32'd0);
        return;
      end
      cycle(1'b0, wdata[i], wmask[i], 1'($urandom));
      if (i == 0) check("wr_oe", 32'({s_dq_oe, s_rwds_oe}), 32'b00);
      model_wr(addr_at(lin, a, i), wdata[i], wmask[i]);
    end
    idle_cycle();
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [15:0] val, input logic refr);
    send_ca(1'b0, 1'b1, 1'b1, a, refr);
    cycle(1'b0, val, 2'($urandom), 1'($urandom));
    if ((a % 32'(Depth)) == 0) model_cr0 = val;
    cycle(1'b0, 16'($urandom), 2'($urandom), 1'($urandom));
    check("regwr_cr0", 32'(s_cr0), 32'(model_cr0));
    check("waitcs_oe", 32'({s_dq_oe, s_rwds_oe, s_busy}), 32'b001);
    idle_cycle();
  endtask

  // ---------------- test sequence ----------------
  logic [15:0] old_w;
  int          kind, n, abort_at;
  logic [31:0] ra;
  logic        rlin, rrefr;

  initial begin
    rst_n = 1'b0;
    cs_n = 1'b1;
    dq_in = '0;
    rwds_in = '0;
    refresh = 1'b0;
    @(posedge clk);
    #1;
    idle_cycle();
    idle_cycle();
    rst_n = 1'b1;
    cycle(1'b1, 16'h0000, 2'b00, 1'b0);
    check("rst_dq", 32'(s_dq), 32'h0);
    check("rst_dq_oe", 32'(s_dq_oe), 32'h0);
    check("rst_rwds", 32'(s_rwds), 32'h0);
    check("rst_rwds_oe", 32'(s_rwds_oe), 32'h0);
    check("rst_busy", 32'(s_busy), 32'h0);
    check("rst_cr0", 32'(s_cr0), 32'(Cr0Rst));
    model_cr0 = Cr0Rst;

    // Fill the whole array with address-tagged words so misaddressing is visible.
    for (int i = 0; i < Depth; i++) begin
      wdata[i] = {6'($urandom), 10'(i)};
      wmask[i] = 2'b00;
    end
    do_write(1'b1, 32'd0, Depth, 1'b0, -1);

    // Word 0x400 folds onto 0; second word only writes its high byte.
    old_w = model_mem[1];
    wdata[0] = 16'hca00; wmask[0] = 2'b00;
    wdata[1] = 16'h00aa; wmask[1] = 2'b01;
    do_write(1'b1, 32'h400, 2, 1'b0, -1);
    exp_q.push_back(16'hca00);
    exp_q.push_back({8'h00, old_w[7:0]});
    do_read(1'b0, 1'b1, 32'h400, 2, 1'b0, 1'b1);

    vecs[0] = mk_vec(1'b1, 32'd1022,       1022, 1023, 0, 1);
    vecs[1] = mk_vec(1'b0, 32'h10e,        'h10e, 'h10f, 'h100, 'h101);
    vecs[2] = mk_vec(1'b0, 32'h3ff,        'h3ff, 'h3f0, 'h3f1, 'h3f2);
    vecs[3] = mk_vec(1'b1, 32'h1234,       'h234, 'h235, 'h236, 'h237);
    vecs[4] = mk_vec(1'b0, 32'h7,          7, 8, 9, 10);
    vecs[5] = mk_vec(1'b1, 32'h40f00f,     'h00f, 'h010, 'h011, 'h012);
    vecs[6] = mk_vec(1'b0, 32'hfffffffe,   'h3fe, 'h3ff, 'h3f0, 'h3f1);
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[vecs[v].exp_addr[i]]);
      do_read(1'b0, vecs[v].lin, vecs[v].start, 4, 1'($urandom), 1'b1);
    end

    // Register space: CR0 write, readback burst, ignored write to address 1.
    reg_write(32'd0, 16'h8f17, 1'b0);
    idle_cycle();
    check("cr0_written", 32'(s_cr0), 32'h8f17);
    exp_q.push_back(16'h8f17);
    exp_q.push_back(16'h0000);
    do_read(1'b1, 1'b1, 32'd0, 2, 1'b0, 1'b1);
    reg_write(32'd1, 16'h1234, 1'b0);
    idle_cycle();
    check("cr0_kept", 32'(s_cr0), 32'h8f17);

    // CS# raised on the second write word: only the first word lands.
    old_w = model_mem['h201];
    wdata[0] = 16'h1111; wmask[0] = 2'b00;
    wdata[1] = 16'h2222; wmask[1] = 2'b00;
    do_write(1'b1, 32'h200, 2, 1'b0, 1);
    exp_q.push_back(16'h1111);
    exp_q.push_back(old_w);
    do_read(1'b0, 1'b1, 32'h200, 2, 1'b0, 1'b1);

    // Partial CA aborted in CA1 and in CA2.
    cycle(1'b0, 16'hffff, 2'b00, 1'b0);
    idle_cycle();
    idle_cycle();
    check("partial1_idle", 32'(s_busy), 32'd0);
    cycle(1'b0, 16'h2000, 2'b00, 1'b0);
    cycle(1'b0, 16'h0000, 2'b00, 1'b0);
    idle_cycle();
    idle_cycle();
    check("partial2_idle", 32'(s_busy), 32'd0);
    do_read(1'b0, 1'b1, 32'd5, 2, 1'b0, 1'b0);

    // Refresh-flagged and plain latency reads.
    do_read(1'b0, 1'b1, 32'h20, 2, 1'b1, 1'b0);
    do_read(1'b0, 1'b0, 32'h20, 2, 1'b0, 1'b0);

    // Reset in the middle of a write burst: committed words persist, CR0 returns to reset.
    send_ca(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    latency(1'b0);
    cycle(1'b0, 16'h3333, 2'b00, 1'b0);
    model_wr('h300, 16'h3333, 2'b00);
    cycle(1'b0, 16'h4444, 2'b10, 1'b0);
    model_wr('h301, 16'h4444, 2'b10);
    rst_n = 1'b0;
    cycle(1'b0, 16'hdead, 2'b11, 1'b0);
    rst_n = 1'b1;
    model_cr0 = Cr0Rst;
    idle_cycle();
    check("midrst_busy", 32'(s_busy), 32'd0);
    check("midrst_cr0", 32'(s_cr0), 32'(Cr0Rst));
    do_read(1'b0, 1'b1, 32'h300, 3, 1'b0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 9);
      n     = $urandom_range(1, 8);
      ra    = $urandom;
      rlin  = 1'($urandom);
      rrefr = 1'($urandom);
      case (kind)
        0: reg_write(32'($urandom_range(0, 2)), 16'($urandom), rrefr);
        1: do_read(1'b1, rlin, 32'($urandom_range(0, 2)), n, rrefr, 1'b0);
        2, 3, 4, 5: begin
          for (int i = 0; i < n; i++) begin
            wdata[i] = 16'($urandom);
            wmask[i] = 2'($urandom);
          end
          abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
          do_write(rlin, ra, n, rrefr, abort_at);
        end
        default: do_read(1'b0, rlin, ra, n, rrefr, 1'b0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
